// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Multicycle control FSM for the PhilosophyV core. One instruction is stepped
// through FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB). The FSM drives the
// IF-register enables, the ALU operand selects, the register-file write
// controls and the req/ready handshakes with instruction and data memory.
// A bounded wait on either memory turns into a fault, and any opcode outside
// the supported set halts the core. HALT is left only through rst.
//
// Optional feature (macro PHILV_SEQ_PERF_CNT_EN):
//   Adds cycle_count (non-HALT cycles) and retired_count (instructions
//   completed). Both wrap and freeze in HALT. With the macro undefined the
//   ports and counters do not exist.
//
// Parameters:
//   OPCODE_WIDTH   - width of the opcode field (7)
//   TIMEOUT_CYCLES - max cycles waiting on a ready before a fault (1..255)
//   CNT_WIDTH      - width of the optional performance counters
//
// Ports:
//   clk, rst                  - rising-edge clock, async active-high reset
//   opcode                    - opcode field from the IF register
//   imem_req / imem_ready     - instruction fetch handshake
//   dmem_req / dmem_we /
//   dmem_ready                - data access handshake (we: 1 store, 0 load)
//   pc_write / ir_write       - IF register enables (pulse on fetch accept)
//   alu_override              - force ADD in the ALU decoder
//   alu_src_a                 - 0 PC, 1 rs1
//   alu_src_b                 - 00 rs2, 01 const 4, 10 immediate
//   reg_write / mem_to_reg    - register file write enable / writeback select
//   halted                    - sticky stop indication
//   fault                     - 00 none, 01 illegal, 10 imem tmo, 11 dmem tmo
//   state                     - current state encoding for debug
//   cycle_count/retired_count - performance counters (optional)
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int OPCODE_WIDTH   = 7,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    imem_req,
  input  logic                    imem_ready,
  output logic                    dmem_req,
  output logic                    dmem_we,
  input  logic                    dmem_ready,
  output logic                    pc_write,
  output logic                    ir_write,
  output logic                    alu_override,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic                    reg_write,
  output logic                    mem_to_reg,
  output logic                    halted,
  output logic [1:0]              fault,
  output logic [2:0]              state
`ifdef PHILV_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]    cycle_count,
  output logic [CNT_WIDTH-1:0]    retired_count
`endif
);

  // State encodings are visible on the debug port, so they are fixed.
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd7
  } state_t;

  // Instruction class captured in DECODE; later states only look at this.
  typedef enum logic [1:0] {
    OP_R     = 2'd0,
    OP_I     = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STORE = 2'd3
  } op_class_t;

  localparam logic [OPCODE_WIDTH-1:0] OPC_R     = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OPC_I     = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD  = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE = OPCODE_WIDTH'(7'b0100011);

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_IMEM    = 2'b10;
  localparam logic [1:0] FAULT_DMEM    = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // Last wait cycle index before a missing ready becomes a fault.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state;
  op_class_t  r_op_class;
  logic [7:0] r_wait_cnt;
  logic [1:0] r_fault;
  logic       r_halted;

  logic       w_op_legal;
  op_class_t  w_op_class;
  logic       w_wait_expired;
  logic [7:0] w_wait_cnt_inc;

  // ---------------------------------------------------------------------------
  // Opcode classification (used only in DECODE)
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    w_op_legal = 1'b1;
    w_op_class = OP_R;
    case (opcode)
      OPC_R:     w_op_class = OP_R;
      OPC_I:     w_op_class = OP_I;
      OPC_LOAD:  w_op_class = OP_LOAD;
      OPC_STORE: w_op_class = OP_STORE;
      default:   w_op_legal = 1'b0;
    endcase
  end

  // The wait counter only ever reaches TIMEOUT_LAST before the FSM leaves,
  // but it saturates anyway so it can never wrap back to a small value.
  assign w_wait_cnt_inc = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
  assign w_wait_expired = (r_wait_cnt >= TIMEOUT_LAST);

  // ---------------------------------------------------------------------------
  // State register, captured instruction class, wait counter, fault and halt
  // ---------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the reset branch is asynchronous and wins immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_op_class <= OP_R;
      r_wait_cnt <= 8'd0;
      r_fault    <= FAULT_NONE;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_state    <= S_DECODE;
            r_wait_cnt <= 8'd0;
          end else if (w_wait_expired) begin
            r_state    <= S_HALT;
            r_fault    <= FAULT_IMEM;
            r_halted   <= 1'b1;
            r_wait_cnt <= 8'd0;
          end else begin
            r_wait_cnt <= w_wait_cnt_inc;
          end
        end

        S_DECODE: begin
          r_wait_cnt <= 8'd0;
          if (w_op_legal) begin
            r_op_class <= w_op_class;
            r_state    <= S_EXECUTE;
          end else begin
            r_state  <= S_HALT;
            r_fault  <= FAULT_ILLEGAL;
            r_halted <= 1'b1;
          end
        end

        S_EXECUTE: begin
          r_wait_cnt <= 8'd0;
          if (r_op_class == OP_LOAD || r_op_class == OP_STORE) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end

        S_MEM: begin
          if (dmem_ready) begin
            r_wait_cnt <= 8'd0;
            r_state    <= (r_op_class == OP_LOAD) ? S_WB : S_FETCH;
          end else if (w_wait_expired) begin
            r_state    <= S_HALT;
            r_fault    <= FAULT_DMEM;
            r_halted   <= 1'b1;
            r_wait_cnt <= 8'd0;
          end else begin
            r_wait_cnt <= w_wait_cnt_inc;
          end
        end

        S_WB: begin
          r_wait_cnt <= 8'd0;
          r_state    <= S_FETCH;
        end

        S_HALT: begin
          r_state <= S_HALT;
        end

        // Unused encodings restart the instruction stream.
        default: begin
          r_wait_cnt <= 8'd0;
          r_state    <= S_FETCH;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the registered state and instruction class
  // ---------------------------------------------------------------------------
  // NOTE: the reset state is FETCH, whose decode would raise imem_req; gating
  // with rst keeps every control output low for as long as reset is held.
  always_comb begin
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    alu_override = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRC_B_RS2;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          // PC + 4 is computed while the fetch is outstanding; the IF
          // register loads in the same cycle the memory returns data.
          imem_req     = 1'b1;
          alu_src_a    = 1'b0;
          alu_src_b    = SRC_B_FOUR;
          alu_override = 1'b1;
          pc_write     = imem_ready;
          ir_write     = imem_ready;
        end

        S_EXECUTE: begin
          alu_src_a = 1'b1;
          case (r_op_class)
            OP_R: begin
              alu_src_b    = SRC_B_RS2;
              alu_override = 1'b0;
            end
            OP_I: begin
              alu_src_b    = SRC_B_IMM;
              alu_override = 1'b0;
            end
            // Loads and stores use the ALU for rs1 + offset.
            OP_LOAD, OP_STORE: begin
              alu_src_b    = SRC_B_IMM;
              alu_override = 1'b1;
            end
            default: begin
              alu_src_b    = SRC_B_RS2;
              alu_override = 1'b0;
            end
          endcase
        end

        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (r_op_class == OP_STORE);
        end

        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (r_op_class == OP_LOAD);
        end

        default: begin
          // DECODE and HALT drive no controls.
        end
      endcase
    end
  end

  assign halted = r_halted;
  assign fault  = r_fault;
  assign state  = r_state;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef PHILV_SEQ_PERF_CNT_EN
  logic w_retire;

  // An instruction retires in WB, or when a store's data access completes
  // (stores skip WB and return straight to FETCH).
  assign w_retire = (r_state == S_WB) ||
                    (r_state == S_MEM && r_op_class == OP_STORE && dmem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else if (r_state != S_HALT) begin
      cycle_count <= cycle_count + CNT_WIDTH'(1);
      if (w_retire) begin
        retired_count <= retired_count + CNT_WIDTH'(1);
      end
    end
  end
`else
  // Keeps the counter width parameter referenced when the counters are absent.
  logic [CNT_WIDTH-1:0] w_unused_cnt_width;
  assign w_unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Directed bench for multicycle_sequencer. Inputs change 1 time unit after a
// rising edge; outputs are compared 1 time unit later, well before the next
// edge. All control outputs are packed into one vector and compared against
// hand-written per-state expectations.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       imem_req;
  logic       imem_ready;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       alu_override;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg_write;
  logic       mem_to_reg;
  logic       halted;
  logic [1:0] fault;
  logic [2:0] state;
`ifdef PHILV_SEQ_PERF_CNT_EN
  logic [31:0] cycle_count;
  logic [31:0] retired_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  multicycle_sequencer #(
    .OPCODE_WIDTH  (7),
    .TIMEOUT_CYCLES(16),
    .CNT_WIDTH     (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .alu_override (alu_override),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .halted       (halted),
    .fault        (fault),
    .state        (state)
`ifdef PHILV_SEQ_PERF_CNT_EN
    ,
    .cycle_count  (cycle_count),
    .retired_count(retired_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output bundle.
  logic [16:0] obs;
  assign obs = {imem_req, dmem_req, dmem_we, pc_write, ir_write, alu_override,
                alu_src_a, alu_src_b, reg_write, mem_to_reg, halted, fault, state};

  function automatic logic [16:0] ob(
    input logic       ir, dr, we, pcw, irw, ovr, sa,
    input logic [1:0] sb,
    input logic       rw, m2r, h,
    input logic [1:0] f,
    input logic [2:0] st
  );
    return {ir, dr, we, pcw, irw, ovr, sa, sb, rw, m2r, h, f, st};
  endfunction

  // Expected bundles per state, written out by hand.
  function automatic logic [16:0] e_fetch(input logic acc);
    return ob(1, 0, 0, acc, acc, 1, 0, 2'b01, 0, 0, 0, 2'b00, 3'd0);
  endfunction
  function automatic logic [16:0] e_decode();
    return ob(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'd1);
  endfunction
  function automatic logic [16:0] e_ex(input logic [1:0] sb, input logic ovr);
    return ob(0, 0, 0, 0, 0, ovr, 1, sb, 0, 0, 0, 2'b00, 3'd2);
  endfunction
  function automatic logic [16:0] e_mem(input logic we);
    return ob(0, 1, we, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 3'd3);
  endfunction
  function automatic logic [16:0] e_wb(input logic m2r);
    return ob(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, m2r, 0, 2'b00, 3'd4);
  endfunction
  function automatic logic [16:0] e_halt(input logic [1:0] f);
    return ob(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, f, 3'd7);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [16:0] exp);
    #1;
    check(tag, {15'd0, obs}, {15'd0, exp});
  endtask

  // Hard stop in case the flow ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    opcode     = '0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    // Reset holds every output low even though the state is FETCH.
    #3;
    check("reset.outputs", {15'd0, obs}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // R-type with zero-wait fetch: states 0,1,2,4,0.
    opcode = OPC_R; imem_ready = 1'b1;
    expect_out("r.fetch_accept", e_fetch(1));
    tick(); imem_ready = 1'b0;
    expect_out("r.decode", e_decode());
    tick();
    expect_out("r.execute", e_ex(2'b00, 0));
    tick();
    expect_out("r.writeback", e_wb(0));
    tick();
    expect_out("r.back_to_fetch", e_fetch(0));

    // I-ALU; opcode changes after DECODE must be ignored.
    opcode = OPC_I; imem_ready = 1'b1;
    expect_out("i.fetch_accept", e_fetch(1));
    tick(); imem_ready = 1'b0;
    expect_out("i.decode", e_decode());
    tick(); opcode = 7'b0000000;
    expect_out("i.execute_opcode_ignored", e_ex(2'b10, 0));
    tick();
    expect_out("i.writeback", e_wb(0));

    // LOAD with dmem_ready three cycles late; a ready in EXECUTE is ignored.
    tick(); opcode = OPC_LOAD; imem_ready = 1'b1;
    expect_out("ld.fetch_accept", e_fetch(1));
    tick(); imem_ready = 1'b0;
    expect_out("ld.decode", e_decode());
    tick(); dmem_ready = 1'b1;
    expect_out("ld.execute_ready_ignored", e_ex(2'b10, 1));
    tick(); dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out("ld.mem_wait", e_mem(0));
      tick();
    end
    dmem_ready = 1'b1;
    expect_out("ld.mem_accept", e_mem(0));
    tick(); dmem_ready = 1'b0;
    expect_out("ld.writeback", e_wb(1));

    // STORE goes MEM -> FETCH with no writeback.
    tick(); opcode = OPC_STORE; imem_ready = 1'b1;
    expect_out("st.fetch_accept", e_fetch(1));
    tick(); imem_ready = 1'b0;
    expect_out("st.decode", e_decode());
    tick();
    expect_out("st.execute", e_ex(2'b10, 1));
    tick(); dmem_ready = 1'b1;
    expect_out("st.mem_accept", e_mem(1));
    tick(); dmem_ready = 1'b0;
    expect_out("st.back_to_fetch", e_fetch(0));
`ifdef PHILV_SEQ_PERF_CNT_EN
    // R(4) + I(4) + LOAD(8) + STORE(4) cycles, four retirements.
    check("perf.cycles_after_store", cycle_count, 32'd20);
    check("perf.retired_after_store", retired_count, 32'd4);
`endif

    // Illegal opcode halts after DECODE and stays halted.
    opcode = 7'b1111111; imem_ready = 1'b1;
    expect_out("ill.fetch_accept", e_fetch(1));
    tick(); imem_ready = 1'b0;
    expect_out("ill.decode", e_decode());
    tick(); opcode = OPC_R;
    expect_out("ill.halt", e_halt(2'b01));
    for (int i = 0; i < 20; i++) begin
      tick();
      imem_ready = i[0];
      dmem_ready = ~i[0];
      expect_out("ill.halt_sticky", e_halt(2'b01));
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
`ifdef PHILV_SEQ_PERF_CNT_EN
    check("perf.cycles_frozen_halt", cycle_count, 32'd22);
    check("perf.retired_frozen_halt", retired_count, 32'd4);
`endif

    // Instruction memory never answers: 16 FETCH cycles, then fault 10.
    rst = 1'b1;
    #1;
    check("reset.from_halt", {15'd0, obs}, 32'd0);
    tick(); rst = 1'b0;
    opcode = OPC_R;
    for (int i = 0; i < 16; i++) begin
      expect_out("tmo_imem.wait", e_fetch(0));
      tick();
    end
    expect_out("tmo_imem.halt", e_halt(2'b10));

    // Ready on the last allowed cycle completes normally.
    rst = 1'b1;
    #1;
    check("reset.from_tmo", {15'd0, obs}, 32'd0);
    tick(); rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      expect_out("edge_imem.wait", e_fetch(0));
      tick();
    end
    imem_ready = 1'b1;
    expect_out("edge_imem.last_cycle_accept", e_fetch(1));
    tick(); imem_ready = 1'b0;
    expect_out("edge_imem.decode", e_decode());
    tick();
    expect_out("edge_imem.execute", e_ex(2'b00, 0));
    tick();
    expect_out("edge_imem.writeback", e_wb(0));

    // Data memory never answers: 16 MEM cycles, then fault 11.
    tick(); opcode = OPC_LOAD; imem_ready = 1'b1;
    expect_out("tmo_dmem.fetch_accept", e_fetch(1));
    tick(); imem_ready = 1'b0;
    expect_out("tmo_dmem.decode", e_decode());
    tick();
    expect_out("tmo_dmem.execute", e_ex(2'b10, 1));
    tick();
    for (int i = 0; i < 16; i++) begin
      expect_out("tmo_dmem.wait", e_mem(0));
      tick();
    end
    expect_out("tmo_dmem.halt", e_halt(2'b11));

    // Reset asserted mid-MEM clears outputs at once, then fetch resumes.
    rst = 1'b1;
    #1;
    check("reset.from_dmem_tmo", {15'd0, obs}, 32'd0);
    tick(); rst = 1'b0;
    opcode = OPC_STORE; imem_ready = 1'b1;
    expect_out("rst_mem.fetch_accept", e_fetch(1));
    tick(); imem_ready = 1'b0;
    expect_out("rst_mem.decode", e_decode());
    tick();
    expect_out("rst_mem.execute", e_ex(2'b10, 1));
    tick();
    expect_out("rst_mem.mem_pending", e_mem(1));
    rst = 1'b1;
    #1;
    check("rst_mem.outputs_cleared", {15'd0, obs}, 32'd0);
    tick(); rst = 1'b0;
    expect_out("rst_mem.resume_fetch", e_fetch(0));
`ifdef PHILV_SEQ_PERF_CNT_EN
    check("perf.cycles_after_reset", cycle_count, 32'd0);
    check("perf.retired_after_reset", retired_count, 32'd0);
`endif
    imem_ready = 1'b1;
    expect_out("rst_mem.fetch_accept_again", e_fetch(1));
    tick(); imem_ready = 1'b0;
    expect_out("rst_mem.decode_again", e_decode());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
